// File: rtl/fetch_addr_gen_pkg.sv
// Shared types and default geometry for the frame fetch address generator.
package fetch_addr_gen_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    localparam int DEF_WORDS_PER_ROW = 80;
    localparam int DEF_ROWS          = 60;
    localparam int DEF_MAX_REPEAT    = 8;
    localparam int DEF_ADDR_W        = 13;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_counter.sv
// Nested column / repeat / row counters with terminal-count flags.
// Advances once per issued word; the repeat limit comes from the frame's
// latched configuration so it cannot change mid-frame.
module fetch_counter
    import fetch_addr_gen_pkg::*;
#(
    parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
    parameter int ROWS          = DEF_ROWS,
    parameter int MAX_REPEAT    = DEF_MAX_REPEAT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clr,
    input  logic                          i_adv,
    input  logic [cnt_w(MAX_REPEAT)-1:0]  i_rpt_lim,
    output logic                          o_col_last,
    output logic                          o_rep_last,
    output logic                          o_row_last
);

    localparam int COL_W = cnt_w(WORDS_PER_ROW);
    localparam int ROW_W = cnt_w(ROWS);
    localparam int RPT_W = cnt_w(MAX_REPEAT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] r_col;
    logic [RPT_W-1:0] r_rep;
    logic [ROW_W-1:0] r_row;

    assign o_col_last = (r_col == COL_LAST);
    assign o_rep_last = (r_rep == i_rpt_lim);
    assign o_row_last = (r_row == ROW_LAST);

    // Column is innermost, then repeat, then row; clear wins over advance.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_col <= '0;
            r_rep <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (!o_col_last) begin
                r_col <= r_col + COL_W'(1);
            end else begin
                r_col <= '0;
                if (!o_rep_last) begin
                    r_rep <= r_rep + RPT_W'(1);
                end else begin
                    r_rep <= '0;
                    r_row <= o_row_last ? '0 : r_row + ROW_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fetch_addr_gen.sv
// Frame fetch address generator: walks a frame row by row, replaying each
// row (cfg_repeat+1) times, and issues one FIFO write per cycle the FIFO
// has room. The issue decision is made one cycle ahead of the write strobe.
module fetch_addr_gen
    import fetch_addr_gen_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
    parameter int ROWS          = DEF_ROWS,
    parameter int MAX_REPEAT    = DEF_MAX_REPEAT,
    parameter int BASE_ADDR     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [cnt_w(MAX_REPEAT)-1:0]  cfg_repeat,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [ADDR_W-1:0]             address,
    output logic                          frame_start,
    output logic                          frame_done
);

    localparam int RPT_W = cnt_w(MAX_REPEAT);

    localparam logic [RPT_W-1:0]  RPT_MAX = RPT_W'(MAX_REPEAT - 1);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WPR_A   = ADDR_W'(WORDS_PER_ROW);

    localparam longint FRAME_END = longint'(BASE_ADDR)
                                 + longint'(ROWS) * longint'(WORDS_PER_ROW);

    // Reject geometries that are empty or that would run past the address space.
    generate
        if (WORDS_PER_ROW < 1 || ROWS < 1 || MAX_REPEAT < 1) begin : g_bad_geom
            $error("fetch_addr_gen: WORDS_PER_ROW, ROWS and MAX_REPEAT must all be >= 1");
        end
        if (FRAME_END > (longint'(1) << ADDR_W)) begin : g_bad_span
            $error("fetch_addr_gen: BASE_ADDR + ROWS*WORDS_PER_ROW exceeds 2**ADDR_W");
        end
    endgenerate

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_row_start;
    logic [RPT_W-1:0]  r_rpt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_fs;
    logic              r_fd;

    logic              w_col_last;
    logic              w_rep_last;
    logic              w_row_last;
    logic              w_issue;
    logic              w_frame_end;
    logic              w_start;
    logic [RPT_W-1:0]  w_rpt_cfg;

    // Out-of-range repeat requests are clamped to the largest allowed count.
    assign w_rpt_cfg   = (cfg_repeat > RPT_MAX) ? RPT_MAX : cfg_repeat;
    assign w_issue     = (r_state == ST_FETCH) && !fifo_full;
    assign w_frame_end = w_issue && w_col_last && w_rep_last && w_row_last;
    // A frame begins from IDLE, or back-to-back when run is still high at the end.
    assign w_start     = run && ((r_state == ST_IDLE) || w_frame_end);

    fetch_counter #(
        .WORDS_PER_ROW (WORDS_PER_ROW),
        .ROWS          (ROWS),
        .MAX_REPEAT    (MAX_REPEAT)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start),
        .i_adv      (w_issue),
        .i_rpt_lim  (r_rpt),
        .o_col_last (w_col_last),
        .o_rep_last (w_rep_last),
        .o_row_last (w_row_last)
    );

    // Frame sequencing, pointer arithmetic and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_row_start <= '0;
            r_rpt       <= '0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
            r_fs        <= 1'b0;
            r_fd        <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_fs    <= 1'b0;
            r_fd    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_rpt       <= w_rpt_cfg;
                        r_ptr       <= BASE_A;
                        r_row_start <= BASE_A;
                        r_fs        <= 1'b1;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_issue) begin
                        r_wr_en <= 1'b1;
                        r_addr  <= r_ptr;
                        if (!w_col_last) begin
                            r_ptr <= r_ptr + ADDR_W'(1);
                        end else if (!w_rep_last) begin
                            // Replay the same row from its first word.
                            r_ptr <= r_row_start;
                        end else if (!w_row_last) begin
                            r_ptr       <= r_row_start + WPR_A;
                            r_row_start <= r_row_start + WPR_A;
                        end else begin
                            r_fd <= 1'b1;
                            if (run) begin
                                // Restart with no idle gap.
                                r_rpt       <= w_rpt_cfg;
                                r_ptr       <= BASE_A;
                                r_row_start <= BASE_A;
                                r_fs        <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_wr_en  = r_wr_en;
    assign address     = r_addr;
    assign frame_start = r_fs;
    assign frame_done  = r_fd;

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Randomized bench for fetch_addr_gen with a queue-based frame model.
module tb_fetch_addr_gen;

    localparam int ADDR_W      = 13;
    localparam int WPR         = 80;
    localparam int ROWS        = 60;
    localparam int MAXR        = 8;
    localparam int BASE        = 0;
    localparam int FRAME_WORDS = ROWS * WPR;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [2:0]        cfg_repeat;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [ADDR_W-1:0] address;
    logic              frame_start;
    logic              frame_done;

    typedef struct {
        int addr;
        bit first;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_wr    = 0;
    int   n_done  = 0;
    bit   fs_seen = 1'b0;

    fetch_addr_gen #(
        .ADDR_W        (ADDR_W),
        .WORDS_PER_ROW (WPR),
        .ROWS          (ROWS),
        .MAX_REPEAT    (MAXR),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .cfg_repeat  (cfg_repeat),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .address     (address),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Expected write sequence of one frame: every row replayed rpt+1 times.
    task automatic push_frame(input int rpt);
        exp_t e;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k <= rpt; k++)
                for (int c = 0; c < WPR; c++) begin
                    e.addr  = BASE + r * WPR + c;
                    e.first = (r == 0 && k == 0 && c == 0);
                    e.last  = (r == ROWS - 1 && k == rpt && c == WPR - 1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: every write must match the model, in order.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (fifo_full) chk("stall_no_wr", fifo_wr_en, 0);
            if (fifo_wr_en) begin
                chk("wr_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("addr", address, e.addr);
                    chk("frame_done_at_wr", frame_done, e.last);
                    chk("frame_start_before_first", fs_seen, e.first);
                end
                fs_seen = 1'b0;
                n_wr++;
            end else begin
                chk("frame_done_no_wr", frame_done, 0);
            end
            if (frame_done) n_done++;
            if (frame_start) fs_seen = 1'b1;
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  i;
        int  base;
        int  d0;
        bit  changed;

        rst = 1'b1; run = 1'b0; cfg_repeat = 3'd0; fifo_full = 1'b0;
        step(); step();
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_addr", address, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_fd", frame_done, 0);
        run = 1'b1;
        step();
        chk("rst_over_run_fs", frame_start, 0);
        chk("rst_over_run_wr", fifo_wr_en, 0);
        run = 1'b0; rst = 1'b0;
        repeat (4) step();
        chk("idle_no_fs", frame_start, 0);
        chk("idle_no_wr", fifo_wr_en, 0);

        // Full frame, repeat 8, no back-pressure; run dropped at row 10.
        cfg_repeat = 3'd7; push_frame(7); base = n_wr; d0 = n_done; run = 1'b1;
        step();
        chk("b_fs_pulse", frame_start, 1);
        chk("b_fs_no_wr", fifo_wr_en, 0);
        cfg_repeat = 3'd2;
        step();
        chk("b_fs_one_cycle", frame_start, 0);
        i = 0;
        while ((n_wr - base) < 10 * WPR * 8 + 3 && i < 20000) begin step(); i++; end
        run = 1'b0;
        i = 0;
        while (n_done == d0 && i < 50000) begin step(); i++; end
        chk("b_done_seen", n_done - d0, 1);
        chk("b_last_addr", address, FRAME_WORDS - 1);
        chk("b_no_restart_fs", frame_start, 0);
        chk("b_words", n_wr - base, FRAME_WORDS * 8);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("b_idle_wr", fifo_wr_en, 0);
        end
        chk("b_queue_empty", exp_q.size(), 0);

        // Repeat 1, targeted stall at ptr=42, then random back-pressure.
        cfg_repeat = 3'd0; push_frame(0); base = n_wr; d0 = n_done; run = 1'b1;
        i = 0;
        while (!(fifo_wr_en && address == 41) && i < 200) begin step(); i++; end
        chk("c_saw_41", address, 41);
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("c_stall_wr", fifo_wr_en, 0);
        end
        fifo_full = 1'b0;
        step();
        chk("c_resume_wr", fifo_wr_en, 1);
        chk("c_resume_addr", address, 42);
        changed = 1'b0;
        i = 0;
        while (n_done == d0 && i < 20000) begin
            if (!changed && (n_wr - base) >= 2000) begin
                cfg_repeat = 3'd3; push_frame(3); changed = 1'b1;
            end
            fifo_full = ((n_wr - base) < FRAME_WORDS - 10) && ($urandom_range(0, 3) == 0);
            step(); i++;
        end
        chk("c_done_seen", n_done - d0, 1);
        chk("c_fd_addr", address, FRAME_WORDS - 1);
        chk("c_fs_with_fd", frame_start, 1);
        chk("c_words", n_wr - base, FRAME_WORDS);
        step();
        chk("c_wrap_wr", fifo_wr_en, 1);
        chk("c_wrap_addr", address, 0);
        chk("c_fs_once", frame_start, 0);

        // Second frame uses repeat 4; reset it at address 1234.
        i = 0;
        while (!(fifo_wr_en && address == 1234) && i < 20000) begin
            fifo_full = ($urandom_range(0, 3) == 0);
            step(); i++;
        end
        chk("d_saw_1234", address, 1234);
        chk("d_repeat_applied", exp_q.size(), 4 * FRAME_WORDS - (15 * WPR * 4 + 35));
        rst = 1'b1; fifo_full = 1'b0;
        step();
        chk("d_rst_wr", fifo_wr_en, 0);
        chk("d_rst_addr", address, 0);
        chk("d_rst_fs", frame_start, 0);
        chk("d_rst_fd", frame_done, 0);
        exp_q.delete(); fs_seen = 1'b0;
        cfg_repeat = 3'd0; push_frame(0); run = 1'b1;
        step();
        chk("d_rst_hold_fs", frame_start, 0);
        rst = 1'b0; base = n_wr; d0 = n_done;
        step();
        chk("d_fs", frame_start, 1);
        chk("d_fs_no_wr", fifo_wr_en, 0);
        step();
        chk("d_first_wr", fifo_wr_en, 1);
        chk("d_first_addr", address, 0);

        // Random back-pressure, run dropped at row 10; frame must still finish.
        i = 0;
        while (n_done == d0 && i < 20000) begin
            if ((n_wr - base) >= 10 * WPR) run = 1'b0;
            fifo_full = ($urandom_range(0, 3) == 0);
            step(); i++;
        end
        chk("e_done_seen", n_done - d0, 1);
        chk("e_fd_addr", address, FRAME_WORDS - 1);
        chk("e_no_fs", frame_start, 0);
        chk("e_words", n_wr - base, FRAME_WORDS);
        for (int k = 0; k < 8; k++) begin
            fifo_full = ($urandom_range(0, 1) == 0);
            step();
            chk("e_idle_wr", fifo_wr_en, 0);
            chk("e_idle_fs", frame_start, 0);
        end
        chk("e_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
